// File: rtl/i2c_target_if.sv
// Host-side bundle of the I2C target: register-file load port, commit
// notifications and status. The host is the master of this interface.
interface i2c_target_if #(
    parameter int NUM_REGS = 16
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic             host_wr_en;
    logic [IDX_W-1:0] host_addr;
    logic [7:0]       host_wr_data;
    logic             i2c_wr_strobe;
    logic [7:0]       i2c_wr_addr;
    logic [7:0]       i2c_wr_data;
    logic             busy;
    logic [3:0]       state_out;

    modport master (
        output host_wr_en, host_addr, host_wr_data,
        input  i2c_wr_strobe, i2c_wr_addr, i2c_wr_data, busy, state_out
    );

    modport slave (
        input  host_wr_en, host_addr, host_wr_data,
        output i2c_wr_strobe, i2c_wr_addr, i2c_wr_data, busy, state_out
    );
endinterface

// File: rtl/i2c_target.sv
// Oversampled I2C target with a byte register file: pointer write, data
// writes, reads with auto-increment. Never stretches SCL; SDA is open-drain.
module i2c_target #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h68,
    parameter int         NUM_REGS       = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        scl,
    inout  wire         sda,
    i2c_target_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        READ      = 4'd7,
        RACK      = 4'd8,
        IGNORE    = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] scl_sync_q, scl_sync_d;
    logic [2:0] sda_sync_q, sda_sync_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       ack_phase_q, ack_phase_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       strobe_q, strobe_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] regs_d [NUM_REGS];

    logic       scl_s, scl_prev, sda_s, sda_prev;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl_s     = scl_sync_q[1];
    assign scl_prev  = scl_sync_q[2];
    assign sda_s     = sda_sync_q[1];
    assign sda_prev  = sda_sync_q[2];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
    assign rx_byte   = {shift_q, sda_s};

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        scl_sync_d  = {scl_sync_q[1:0], scl};
        sda_sync_d  = {sda_sync_q[1:0], sda};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        ack_phase_d = ack_phase_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        strobe_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;

        // Host write first so a same-index I2C commit below overrides it.
        if (bus.host_wr_en) regs_d[bus.host_addr] = bus.host_wr_data;

        if (start_det) begin
            state_d     = ADDR;
            bit_cnt_d   = 4'd0;
            ack_phase_d = 1'b0;
            sda_oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d   = 4'd0;
                            ack_phase_d = 1'b0;
                            if (state_q == ADDR) begin
                                if (rx_byte[7:1] == DEVICE_ADDRESS) begin
                                    rw_d    = rx_byte[0];
                                    busy_d  = 1'b1;
                                    state_d = ADDR_ACK;
                                end else begin
                                    busy_d  = 1'b0;
                                    state_d = IGNORE;
                                end
                            end else if (state_q == PTR) begin
                                ptr_d   = rx_byte;
                                state_d = PTR_ACK;
                            end else begin
                                regs_d[ptr_q[IDX_W-1:0]] = rx_byte;
                                strobe_d  = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = rx_byte;
                                ptr_d     = ptr_q + 8'd1;
                                state_d   = WDATA_ACK;
                            end
                        end
                    end
                end
                // First fall after the byte pulls SDA low; the next ends the ACK clock.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_oe_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end else begin
                            ack_phase_d = 1'b0;
                            sda_oe_d    = 1'b0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                tx_d     = regs_q[ptr_q[IDX_W-1:0]];
                                sda_oe_d = ~tx_d[7];
                                state_d  = READ;
                            end else if (state_q == ADDR_ACK) begin
                                state_d = PTR;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                READ: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            bit_cnt_d   = 4'd0;
                            ack_phase_d = 1'b0;
                            sda_oe_d    = 1'b0;
                            state_d     = RACK;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_d[7];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            busy_d  = 1'b0;
                            state_d = IGNORE;
                        end else begin
                            ptr_d       = ptr_q + 8'd1;
                            ack_phase_d = 1'b1;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        ack_phase_d = 1'b0;
                        tx_d        = regs_q[ptr_q[IDX_W-1:0]];
                        sda_oe_d    = ~tx_d[7];
                        state_d     = READ;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: synchronisers reset to the idle-bus level so release cannot fake an edge.
            scl_sync_q  <= 3'b111;
            sda_sync_q  <= 3'b111;
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 7'd0;
            tx_q        <= 8'd0;
            ptr_q       <= 8'd0;
            rw_q        <= 1'b0;
            ack_phase_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            strobe_q    <= 1'b0;
            wr_addr_q   <= 8'd0;
            wr_data_q   <= 8'd0;
            // NOTE: the register file must read back zero after reset, so it is
            // built from resettable flops rather than a RAM macro.
            regs_q      <= '{default: 8'd0};
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            ack_phase_q <= ack_phase_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            strobe_q    <= strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    assign sda               = sda_oe_q ? 1'b0 : 1'bz;
    assign bus.i2c_wr_strobe = strobe_q;
    assign bus.i2c_wr_addr   = wr_addr_q;
    assign bus.i2c_wr_data   = wr_data_q;
    assign bus.busy          = busy_q;
    assign bus.state_out     = state_q;
endmodule
